// File: rtl/sram_sync_1r1w_pkg.sv
// Shared constants and elaboration helpers for the 1R1W synchronous SRAM.
// Optional write-first bypass is selected with SRAM_SYNC_1R1W_WRITE_BYPASS_EN.
package sram_pkg;

  localparam int SRAM_DATA_WIDTH = 32'sd128;
  localparam int SRAM_ADDR_WIDTH = 32'sd12;
  localparam int SRAM_DEPTH      = 32'sd4096;

  // True when a memory of the given depth is addressable with addr_width bits.
  function automatic bit sram_depth_ok(input int depth, input int addr_width);
    return (depth >= 32'sd1) && (64'(depth) <= (64'd1 << addr_width));
  endfunction

endpackage

// File: rtl/sram_sync_1r1w_if.sv
// Read/write port bundle for sram_sync_1r1w; the memory takes the slave side.
interface sram_sync_1r1w_if
  import sram_pkg::*;
#(
  parameter int data_width = SRAM_DATA_WIDTH,
  parameter int addr_width = SRAM_ADDR_WIDTH
);

  logic                  re;
  logic [addr_width-1:0] radr;
  logic                  we;
  logic [addr_width-1:0] wadr;
  logic [data_width-1:0] d;
  logic [data_width-1:0] q;

  modport master (output re, radr, we, wadr, d, input q);
  modport slave  (input re, radr, we, wadr, d, output q);

endinterface

// File: rtl/sram_sync_1r1w_array.sv
// Pure storage for the 1R1W SRAM: one synchronous write port and an
// asynchronous read mux. No reset; contents survive rst_n.
module sram_sync_1r1w_array
  import sram_pkg::*;
#(
  parameter int data_width = SRAM_DATA_WIDTH,
  parameter int addr_width = SRAM_ADDR_WIDTH,
  parameter int depth      = SRAM_DEPTH
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [addr_width-1:0] wadr_i,
  input  logic [data_width-1:0] d_i,
  input  logic [addr_width-1:0] radr_i,
  output logic [data_width-1:0] rdata_o
);

  logic [data_width-1:0] mem_q [depth];

  // Write port; we_i arrives already qualified by reset and address range.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wadr_i] <= d_i;
    end
  end

  assign rdata_o = mem_q[radr_i];

endmodule

// File: rtl/sram_sync_1r1w.sv
// Synchronous 1R1W RAM with registered read data (1-cycle latency).
// Define SRAM_SYNC_1R1W_WRITE_BYPASS_EN for write-first same-address reads.
module sram_sync_1r1w
  import sram_pkg::*;
#(
  parameter int data_width = SRAM_DATA_WIDTH,
  parameter int addr_width = SRAM_ADDR_WIDTH,
  parameter int depth      = SRAM_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  sram_sync_1r1w_if.slave  bus
);

  if (!sram_depth_ok(depth, addr_width)) begin : g_depth_chk
    $error("sram_sync_1r1w: depth %0d not addressable with addr_width %0d", depth, addr_width);
  end

  // One extra bit so depth == 2**addr_width compares correctly.
  localparam logic [addr_width:0] DEPTH_L = (addr_width+1)'(depth);

  logic                  wr_ok_s;
  logic                  rd_ok_s;
  logic                  wr_en_s;
  logic                  bypass_s;
  logic [data_width-1:0] rdata_s;
  logic [data_width-1:0] rd_val_s;
  logic [data_width-1:0] q_d;
  logic [data_width-1:0] q_q;

  assign wr_ok_s = ({1'b0, bus.wadr} < DEPTH_L);
  assign rd_ok_s = ({1'b0, bus.radr} < DEPTH_L);
  assign wr_en_s = bus.we & rst_n & wr_ok_s;

`ifdef SRAM_SYNC_1R1W_WRITE_BYPASS_EN
  assign bypass_s = wr_en_s & (bus.radr == bus.wadr);
`else
  assign bypass_s = 1'b0;
`endif

  sram_sync_1r1w_array #(
    .data_width (data_width),
    .addr_width (addr_width),
    .depth      (depth)
  ) u_array (
    .clk     (clk),
    .we_i    (wr_en_s),
    .wadr_i  (bus.wadr),
    .d_i     (bus.d),
    .radr_i  (bus.radr),
    .rdata_o (rdata_s)
  );

  // Next read value; ternaries keep an X on re visible in q rather than masked.
  always_comb begin
    rd_val_s = {data_width{1'b0}};
    q_d      = q_q;
    rd_val_s = rd_ok_s ? (bypass_s ? bus.d : rdata_s) : {data_width{1'b0}};
    q_d      = bus.re ? rd_val_s : q_q;
  end

  // Read data register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= {data_width{1'b0}};
    end else begin
      q_q <= q_d;
    end
  end

  assign bus.q = q_q;

endmodule

// File: tb/tb_sram_sync_1r1w.sv
// Directed, table-driven bench for sram_sync_1r1w (default and depth=3000 instances).
module tb_sram_sync_1r1w;

  localparam int DW = 128;
  localparam int AW = 12;

  typedef struct {
    logic          re;
    logic [AW-1:0] radr;
    logic          we;
    logic [AW-1:0] wadr;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_q;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;

  vec_t vecs [64];
  int   nvec = 0;

  sram_sync_1r1w_if #(.data_width(DW), .addr_width(AW)) bus_a ();
  sram_sync_1r1w_if #(.data_width(DW), .addr_width(AW)) bus_b ();

  sram_sync_1r1w #(.data_width(DW), .addr_width(AW), .depth(4096)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  sram_sync_1r1w #(.data_width(DW), .addr_width(AW), .depth(3000)) u_dut_oor (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic re, input int radr, input logic we, input int wadr,
                     input logic [DW-1:0] d, input logic [DW-1:0] exp_q);
    vecs[nvec].re    = re;
    vecs[nvec].radr  = AW'(radr);
    vecs[nvec].we    = we;
    vecs[nvec].wadr  = AW'(wadr);
    vecs[nvec].d     = d;
    vecs[nvec].exp_q = exp_q;
    nvec++;
  endtask

  task automatic drive_a(input logic re, input int radr, input logic we, input int wadr,
                         input logic [DW-1:0] d);
    bus_a.re   = re;
    bus_a.radr = AW'(radr);
    bus_a.we   = we;
    bus_a.wadr = AW'(wadr);
    bus_a.d    = d;
  endtask

  task automatic drive_b(input logic re, input int radr, input logic we, input int wadr,
                         input logic [DW-1:0] d);
    bus_b.re   = re;
    bus_b.radr = AW'(radr);
    bus_b.we   = we;
    bus_b.wadr = AW'(wadr);
    bus_b.d    = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] ones;
  logic [DW-1:0] collide_exp;

  initial begin
    ones = {DW{1'b1}};
`ifdef SRAM_SYNC_1R1W_WRITE_BYPASS_EN
    collide_exp = 128'h55;
`else
    collide_exp = 128'hAA;
`endif

    // Table: basic, hold, collision, then concurrent ports with reads lagging by 2.
    add(1'b0, 0, 1'b1, 0, ones,        128'h0);
    add(1'b1, 0, 1'b0, 0, 128'h0,      ones);
    add(1'b1, 0, 1'b0, 0, 128'h0,      ones);
    add(1'b0, 0, 1'b1, 5, 128'h1234,   ones);
    add(1'b1, 5, 1'b0, 0, 128'h0,      128'h1234);
    add(1'b0, 0, 1'b1, 5, 128'hBEEF,   128'h1234);
    add(1'b0, 5, 1'b0, 0, 128'h0,      128'h1234);
    add(1'b1, 5, 1'b0, 0, 128'h0,      128'hBEEF);
    add(1'b0, 0, 1'b1, 7, 128'hAA,     128'hBEEF);
    add(1'b1, 7, 1'b1, 7, 128'h55,     collide_exp);
    add(1'b1, 7, 1'b0, 0, 128'h0,      128'h55);
    add(1'b0, 0, 1'b1, 4095, 128'hC0DE, 128'h55);
    add(1'b1, 4095, 1'b0, 0, 128'h0,   128'hC0DE);
    for (int i = 0; i < 18; i++) begin
      add(i >= 2, (i >= 2) ? i - 2 : 0, i < 16, i, DW'(i),
          (i >= 2) ? DW'(i - 2) : 128'hC0DE);
    end

    drive_a(1'b0, 0, 1'b0, 0, 128'h0);
    drive_b(1'b0, 0, 1'b0, 0, 128'h0);
    #2 rst_n = 1'b0;
    #1;
    check("reset_q_a", bus_a.q, 128'h0);
    check("reset_q_b", bus_b.q, 128'h0);
    step();
    check("reset_hold_q_a", bus_a.q, 128'h0);
    #3 rst_n = 1'b1;

    for (int i = 0; i < nvec; i++) begin
      drive_a(vecs[i].re, int'(vecs[i].radr), vecs[i].we, int'(vecs[i].wadr), vecs[i].d);
      step();
      if (bus_a.q !== vecs[i].exp_q) begin
        $display("FAIL vec%0d: got %h expected %h", i, bus_a.q, vecs[i].exp_q);
        errors++;
      end
      checks++;
    end

    // Async reset mid-cycle clears q; contents survive, writes under reset ignored.
    drive_a(1'b0, 0, 1'b1, 20, 128'hFFFF);
    step();
    drive_a(1'b1, 20, 1'b0, 0, 128'h0);
    step();
    check("pre_reset_q", bus_a.q, 128'hFFFF);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_q", bus_a.q, 128'h0);
    drive_a(1'b1, 20, 1'b1, 20, 128'hDEAD);
    step();
    check("reset_held_q", bus_a.q, 128'h0);
    drive_a(1'b1, 20, 1'b0, 0, 128'h0);
    #3 rst_n = 1'b1;
    step();
    check("post_reset_first_read", bus_a.q, 128'hFFFF);
    drive_a(1'b0, 0, 1'b0, 0, 128'h0);

    // Out-of-range on the depth=3000 instance.
    drive_b(1'b0, 0, 1'b1, 404, 128'h404);
    step();
    drive_b(1'b0, 0, 1'b1, 2999, 128'h2999);
    step();
    drive_b(1'b1, 404, 1'b1, 3500, 128'h77);
    step();
    check("oor_b_read404", bus_b.q, 128'h404);
    drive_b(1'b1, 3500, 1'b0, 0, 128'h0);
    step();
    check("oor_b_read3500", bus_b.q, 128'h0);
    drive_b(1'b1, 2999, 1'b0, 0, 128'h0);
    step();
    check("oor_b_read_last", bus_b.q, 128'h2999);
    drive_b(1'b1, 3000, 1'b0, 0, 128'h0);
    step();
    check("oor_b_read3000", bus_b.q, 128'h0);
    drive_b(1'b1, 404, 1'b0, 0, 128'h0);
    step();
    check("oor_b_404_unchanged", bus_b.q, 128'h404);
    drive_b(1'b1, 3500, 1'b1, 3500, 128'h99);
    step();
    check("oor_b_collide", bus_b.q, 128'h0);
    drive_b(1'b0, 0, 1'b0, 0, 128'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_sync_1r1w.md
Name: sram_sync_1r1w

Overview:
- Synchronous single-clock RAM with one read port and one write port, both usable in the same cycle.
- Backing store for HLS-generated datapaths (convolution buffers); used wherever the tool maps an array to a 1R1W memory.
- Registered read data with 1-cycle latency.
- Clock is `clk`; reset is `rst_n`, asynchronous and active-low.

Parameters:
- data_width, 128, bits per word.
- addr_width, 12, bits per address.
- depth, 4096, number of words; must be ≤ 2**addr_width and ≥ 1.

Ports:
- clk  in  1  clock; all sampling on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- re  in  1  read enable.
- radr  in  addr_width  read address.
- we  in  1  write enable.
- wadr  in  addr_width  write address.
- d  in  data_width  write data.
- q  out  data_width  registered read data.

Behaviour:
- Reset:
  - rst_n low forces q to 0 immediately, independent of clk, and holds it at 0 while low.
  - Memory array contents are NOT reset; they are retained across reset.
  - Writes and reads are ignored while rst_n is low.
- Write: at a rising edge with we=1 and wadr<depth, mem[wadr] <= d. With we=0, memory is unchanged.
- Read:
  - At a rising edge with re=1 and radr<depth, q <= mem[radr]. Data is visible after that edge (1-cycle latency).
  - With re=0, q holds its previous value.
- Out of range (address ≥ depth, only possible when depth < 2**addr_width):
  - Write is dropped.
  - Read loads q with 0.
- Read-during-write to the same address in the same cycle: q returns the OLD contents (read-before-write), unless WRITE_BYPASS_EN is defined.
- Read and write to different addresses in the same cycle are fully independent.
- Uninitialised words read as X in simulation; no initialisation is required.
- Reset released mid-sequence:
  - The first rising edge with rst_n high performs normal operation.
  - No extra dead cycle.
- X on we or re propagates as X (no silent masking).

Optional Feature:
- Macro: SRAM_SYNC_1R1W_WRITE_BYPASS_EN.
- Defined:
  - On re=1, we=1, radr==wadr (in range), q <= d, giving write-first semantics.
  - Memory is still written.
- Not defined: read-before-write; q <= old mem[radr].
- Either way, the out-of-range rules above take precedence.

Decomposition:
- Package sram_pkg holds:
  - default constants SRAM_DATA_WIDTH=128, SRAM_ADDR_WIDTH=12, SRAM_DEPTH=4096;
  - a function checking that depth ≤ 2**addr_width, used in an elaboration-time assertion.
- One sub-module, sram_sync_1r1w_array:
  - pure storage (reg array, write port, combinational read mux);
  - instantiated by the top, which owns the q register, reset, bypass compare and range checks.

Test Plan:
- Basic write/read, default parameters:
  - After reset release, we=1, wadr=0, d=all-ones for one cycle.
  - Then we=0; next cycle re=1, radr=0.
  - Expect q=128'hFFFF…FFFF one cycle after re is sampled, and stable while re stays 1.
- Hold:
  - Write 0x1234 to addr 5 and read it.
  - Drop re, then write 0xBEEF to addr 5.
  - Expect q stays 0x1234 until re is reasserted, then q=0xBEEF.
- Same-address collision: mem[7]=0xAA; same cycle we=1, wadr=7, d=0x55, re=1, radr=7.
  - Without macro: q=0xAA, next read 0x55.
  - With macro: q=0x55.
- Async reset:
  - q=0xFFFF; assert rst_n low between clock edges.
  - Expect q=0 immediately.
  - Release, re=1 on the previously written address.
  - Expect original data, since contents were retained.
- Out of range, depth=3000:
  - Write 0x77 to wadr=3500.
  - Read radr=3500: expect q=0.
  - Read wadr=3500 mod 4096 region is unaffected; address 404 is unchanged.
- Concurrent independent ports:
  - Back-to-back writes to addr 0..15 with data=addr.
  - Simultaneous reads lagging by 2 addresses.
  - Expect q=radr-value on each following cycle.
